alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
// Shares the single OTTER ALU between two requesters (REQ0: execute stage,
// REQ1: auxiliary/multi-cycle unit) using valid/ready handshakes.
// Arbitrates, registers operands, drives the ALU for one cycle, captures the result.
// Holds the result until the owning requester accepts it.
// PARAMETERS
// WIDTH      32  operand/result width
// FUN_W      4   ALU function code width
// PRIO_MODE  0   0 = round-robin, 1 = fixed priority (REQ0 always wins)
// PORTS
// CLK          in   1      system clock, rising edge
// RST_N        in   1      asynchronous reset, active-low
// REQn_VALID   in   1      n=0,1: request present; A/B/FUN stable while high
// REQn_READY   out  1      n=0,1: request accepted when VALID&READY
// REQn_A       in   WIDTH  n=0,1: operand A
// REQn_B       in   WIDTH  n=0,1: operand B
// REQn_FUN     in   FUN_W  n=0,1: ALU function code, passed through unchecked
// REQn_RVALID  out  1      n=0,1: result valid for requester n
// REQn_RREADY  in   1      n=0,1: requester n takes result
// REQn_RESULT  out  WIDTH  n=0,1: both driven from the shared result register
// ALU_A        out  WIDTH  to ALU operand A (registered)
// ALU_B        out  WIDTH  to ALU operand B (registered)
// ALU_FUN      out  FUN_W  to ALU function select (registered)
// ALU_RESULT   in   WIDTH  from ALU, combinational
// BEHAVIOUR
// - One clock (CLK); reset is asynchronous and active-low (RST_N).
// - Reset values: state IDLE; ALU_A/ALU_B/ALU_FUN = 0; result reg = 0;
//   REQn_RVALID = 0; owner = 0; last_grant = 1, so REQ0 wins the first tie.
// - FSM states: IDLE -> EXEC -> RESP -> IDLE.
// - IDLE: REQn_READY = 1 only for the arbitration winner among VALID requesters,
//   combinational on VALID. All other READYs are 0.
//   - On a handshake edge: latch A/B/FUN into the ALU_* regs, record owner, go to EXEC.
// - Arbitration:
//   - PRIO_MODE=0: if both are valid, the requester != last_grant wins.
//     last_grant updates on each handshake.
//   - PRIO_MODE=1: REQ0 wins whenever valid.
// - EXEC (exactly 1 cycle): ALU_* are stable. At the end edge, ALU_RESULT is
//   registered into the result reg. Go to RESP.
// - RESP: REQowner_RVALID = 1; the other RVALID = 0.
//   - On REQowner_RREADY, go to IDLE.
//   - Non-owner RREADY is ignored.
// - READY = 0 in EXEC and RESP. Only one transaction is in flight; no back-to-back
//   accept from RESP. Minimum spacing between accepts is 3 cycles.
// - Latency: handshake at edge k; RVALID is high from cycle k+2 until the RREADY
//   edge. RESULT and RVALID stay stable under backpressure.
// - ALU_* hold their last operands in IDLE and RESP; they change only on a handshake.
// - Width rule: no arithmetic in this block. The result is the ALU output, bit-exact.
//   Invalid FUN codes go to the ALU unchanged; the ALU returns 0.
// - VALID dropped before grant: no effect, no state change.
// - Simultaneous VALID on both requesters: exactly one READY is asserted, never both.
// - Fairness: in round-robin mode, a continuously valid requester is granted within
//   one other transaction. Fixed mode may starve REQ1 (documented, intended).
// - Reset mid-operation (EXEC or RESP): outputs go to reset values immediately.
//   The in-flight transaction is dropped; no RVALID after release.
// TESTING
// 1. REQ0 add A=5,B=7,FUN=0000 -> REQ0_READY same cycle; REQ0_RVALID 2 cycles later,
//    RESULT=12; IDLE after RREADY.
// 2. Both VALID from reset, RR: REQ0 sub 10,3 and REQ1 sltu 1,0xFFFFFFFF
//    -> REQ0 granted first, RESULT=7; then REQ1, RESULT=1.
// 3. PRIO_MODE=1, REQ0 continuously valid, REQ1 valid -> REQ1_READY never asserts;
//    REQ0 results in order.
// 4. REQ1 sra 0x80000000,4 with RREADY low 5 cycles -> RESULT=0xF8000000 stable,
//    REQ1_RVALID high, both READYs 0 throughout.
// 5. FUN=1111 (invalid) -> RESULT=0; FUN=1001 lui A=0xABCD0000 -> RESULT=0xABCD0000.
// 6. RST_N low during EXEC -> RVALIDs 0, ALU_* 0 asynchronously; no RVALID after
//    release; next request served normally.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two valid/ready requesters.
// One transaction in flight: arbitrate in IDLE, drive the registered operands
// for one EXEC cycle, then hold the captured result in RESP until the owner
// takes it.
module alu_arbiter #(
  parameter int WIDTH     = 32,
  parameter int FUN_W     = 4,
  parameter int PRIO_MODE = 0   // 0: round-robin, 1: REQ0 always wins
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ0_VALID,
  output logic             REQ0_READY,
  input  logic [WIDTH-1:0] REQ0_A,
  input  logic [WIDTH-1:0] REQ0_B,
  input  logic [FUN_W-1:0] REQ0_FUN,
  output logic             REQ0_RVALID,
  input  logic             REQ0_RREADY,
  output logic [WIDTH-1:0] REQ0_RESULT,
  input  logic             REQ1_VALID,
  output logic             REQ1_READY,
  input  logic [WIDTH-1:0] REQ1_A,
  input  logic [WIDTH-1:0] REQ1_B,
  input  logic [FUN_W-1:0] REQ1_FUN,
  output logic             REQ1_RVALID,
  input  logic             REQ1_RREADY,
  output logic [WIDTH-1:0] REQ1_RESULT,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [FUN_W-1:0] ALU_FUN,
  input  logic [WIDTH-1:0] ALU_RESULT
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  logic [1:0]            req_valid, req_rready, grant, rvalid;
  logic [1:0][WIDTH-1:0] req_a, req_b;
  logic [1:0][FUN_W-1:0] req_fun;

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_grant_q, last_grant_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [FUN_W-1:0] alu_fun_q, alu_fun_d;
  logic [WIDTH-1:0] result_q, result_d;

  assign req_valid  = {REQ1_VALID, REQ0_VALID};
  assign req_rready = {REQ1_RREADY, REQ0_RREADY};
  assign req_a      = {REQ1_A, REQ0_A};
  assign req_b      = {REQ1_B, REQ0_B};
  assign req_fun    = {REQ1_FUN, REQ0_FUN};

  // Arbitration: only in IDLE, one-hot grant, combinational on VALID.
  always_comb begin
    grant = 2'b00;
    if (state_q == IDLE) begin
      if (PRIO_MODE != 0) begin
        if (req_valid[0])      grant = 2'b01;
        else if (req_valid[1]) grant = 2'b10;
      end else if (req_valid == 2'b11) begin
        // tie goes to whoever was not granted last
        grant = last_grant_q ? 2'b01 : 2'b10;
      end else begin
        grant = req_valid;
      end
    end
  end

  // Next-state: capture operands on grant, result after the EXEC cycle.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_fun_d    = alu_fun_q;
    result_d     = result_q;
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          state_d      = EXEC;
          owner_d      = grant[1];
          last_grant_d = grant[1];
          alu_a_d      = req_a[grant[1]];
          alu_b_d      = req_b[grant[1]];
          alu_fun_d    = req_fun[grant[1]];
        end
      end
      EXEC: begin
        result_d = ALU_RESULT;
        state_d  = RESP;
      end
      RESP: begin
        // non-owner RREADY has no effect
        if (req_rready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and registered datapath; reset drops any in-flight transaction.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_fun_q    <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_fun_q    <= alu_fun_d;
      result_q     <= result_d;
    end
  end

  // Result valid only toward the owner while waiting in RESP.
  always_comb begin
    rvalid = 2'b00;
    if (state_q == RESP) rvalid[owner_q] = 1'b1;
  end

  assign REQ0_READY  = grant[0];
  assign REQ1_READY  = grant[1];
  assign REQ0_RVALID = rvalid[0];
  assign REQ1_RVALID = rvalid[1];
  assign REQ0_RESULT = result_q;
  assign REQ1_RESULT = result_q;
  assign ALU_A       = alu_a_q;
  assign ALU_B       = alu_b_q;
  assign ALU_FUN     = alu_fun_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: two arbiters (round-robin and fixed priority), each with a
// behavioural OTTER ALU on its ALU port. Directed cases followed by random
// traffic checked against a transaction-level model.
module tb_alu_arbiter;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  // index [d][n]: d = instance (0 round-robin, 1 fixed), n = requester
  logic [1:0][1:0]       v, rr, rdy, rv;
  logic [1:0][1:0][31:0] a, b, res;
  logic [1:0][1:0][3:0]  f;
  logic [1:0][31:0]      alua, alub, alur;
  logic [1:0][3:0]       aluf;

  int errs = 0;
  int nchk = 0;

  // OTTER ALU; unknown codes return 0
  function automatic logic [31:0] alu_ref(input logic [31:0] x, input logic [31:0] y,
                                          input logic [3:0] fn);
    case (fn)
      4'b0000: return x + y;
      4'b1000: return x - y;
      4'b0110: return x | y;
      4'b0111: return x & y;
      4'b0100: return x ^ y;
      4'b0101: return x >> y[4:0];
      4'b0001: return x << y[4:0];
      4'b1101: return $unsigned($signed(x) >>> y[4:0]);
      4'b0010: return {31'd0, $signed(x) < $signed(y)};
      4'b0011: return {31'd0, x < y};
      4'b1001: return x;
      default: return 32'd0;
    endcase
  endfunction

  assign alur[0] = alu_ref(alua[0], alub[0], aluf[0]);
  assign alur[1] = alu_ref(alua[1], alub[1], aluf[1]);

  alu_arbiter #(.WIDTH(32), .FUN_W(4), .PRIO_MODE(0)) u_rr (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0_VALID(v[0][0]), .REQ0_READY(rdy[0][0]), .REQ0_A(a[0][0]), .REQ0_B(b[0][0]),
    .REQ0_FUN(f[0][0]), .REQ0_RVALID(rv[0][0]), .REQ0_RREADY(rr[0][0]), .REQ0_RESULT(res[0][0]),
    .REQ1_VALID(v[0][1]), .REQ1_READY(rdy[0][1]), .REQ1_A(a[0][1]), .REQ1_B(b[0][1]),
    .REQ1_FUN(f[0][1]), .REQ1_RVALID(rv[0][1]), .REQ1_RREADY(rr[0][1]), .REQ1_RESULT(res[0][1]),
    .ALU_A(alua[0]), .ALU_B(alub[0]), .ALU_FUN(aluf[0]), .ALU_RESULT(alur[0])
  );

  alu_arbiter #(.WIDTH(32), .FUN_W(4), .PRIO_MODE(1)) u_fp (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0_VALID(v[1][0]), .REQ0_READY(rdy[1][0]), .REQ0_A(a[1][0]), .REQ0_B(b[1][0]),
    .REQ0_FUN(f[1][0]), .REQ0_RVALID(rv[1][0]), .REQ0_RREADY(rr[1][0]), .REQ0_RESULT(res[1][0]),
    .REQ1_VALID(v[1][1]), .REQ1_READY(rdy[1][1]), .REQ1_A(a[1][1]), .REQ1_B(b[1][1]),
    .REQ1_FUN(f[1][1]), .REQ1_RVALID(rv[1][1]), .REQ1_RREADY(rr[1][1]), .REQ1_RESULT(res[1][1]),
    .ALU_A(alua[1]), .ALU_B(alub[1]), .ALU_FUN(aluf[1]), .ALU_RESULT(alur[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    v = '0; rr = '0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // One directed transaction from requester n of instance d, entered at a
  // negedge. keep: VALID stays high after the grant. poke: the other
  // requester raises VALID and RREADY while this one is in flight.
  task automatic do_txn(input int d, input int n, input logic [31:0] ta, input logic [31:0] tb,
                        input logic [3:0] tf, input int hold, input logic [31:0] exp,
                        input bit keep, input bit poke);
    string s = $sformatf("d%0d_req%0d", d, n);
    a[d][n] = ta; b[d][n] = tb; f[d][n] = tf; v[d][n] = 1'b1; rr[d][n] = 1'b0;
    #1;
    chk({s, "_ready"}, rdy[d][n], 1);
    chk({s, "_other_ready"}, rdy[d][1-n], 0);
    @(negedge CLK);
    if (!keep) v[d][n] = 1'b0;
    if (poke) begin v[d][1-n] = 1'b1; rr[d][1-n] = 1'b1; end
    #1;
    chk({s, "_exec_rvalid"}, rv[d][n], 0);
    chk({s, "_exec_ready"}, {rdy[d][0], rdy[d][1]}, 0);
    chk({s, "_alu_a"}, alua[d], ta);
    chk({s, "_alu_b"}, alub[d], tb);
    chk({s, "_alu_fun"}, aluf[d], tf);
    @(negedge CLK);
    for (int i = 0; i <= hold; i++) begin
      #1;
      chk({s, "_rvalid"}, rv[d][n], 1);
      chk({s, "_other_rvalid"}, rv[d][1-n], 0);
      chk({s, "_result"}, res[d][n], exp);
      chk({s, "_resp_ready"}, {rdy[d][0], rdy[d][1]}, 0);
      if (i < hold) @(negedge CLK);
    end
    rr[d][n] = 1'b1;
    @(negedge CLK);
    rr[d][n] = 1'b0;
    if (poke) begin v[d][1-n] = 1'b0; rr[d][1-n] = 1'b0; end
    #1;
    chk({s, "_rvalid_cleared"}, rv[d][n], 0);
  endtask

  // Random traffic on instance d against a transaction-level model: a single
  // pending job that becomes visible two edges after acceptance and retires
  // on the owner's RREADY.
  task automatic rand_run(input int d, input int cycles);
    logic [3:0] funs [12] = '{4'd0, 4'd8, 4'd6, 4'd7, 4'd4, 4'd5, 4'd1, 4'd13, 4'd2, 4'd3, 4'd9, 4'd15};
    bit pend = 0;
    int own = 0, age = 0, lastg = 1;
    bit [1:0] acc = '0, w;
    logic [31:0] ea = '0, eres = '0;
    logic [3:0] ef = '0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge CLK);
      for (int n = 0; n < 2; n++) begin
        rr[d][n] = 1'($urandom_range(0, 1));
        if (!v[d][n] || acc[n]) begin
          v[d][n] = ($urandom_range(0, 2) != 0);
          a[d][n] = $urandom;
          b[d][n] = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
          f[d][n] = funs[$urandom_range(0, 11)];
        end else if ($urandom_range(0, 9) == 0) begin
          v[d][n] = 1'b0;
        end
      end
      acc = '0;
      #1;
      w[0] = !pend && v[d][0] && (d == 1 || !v[d][1] || lastg == 1);
      w[1] = !pend && v[d][1] && !w[0];
      chk("rnd_ready0", rdy[d][0], w[0]);
      chk("rnd_ready1", rdy[d][1], w[1]);
      chk("rnd_rvalid0", rv[d][0], pend && age >= 2 && own == 0);
      chk("rnd_rvalid1", rv[d][1], pend && age >= 2 && own == 1);
      if (pend && age >= 2) chk("rnd_result", res[d][own], eres);
      if (pend) begin
        chk("rnd_alu_a", alua[d], ea);
        chk("rnd_alu_fun", aluf[d], ef);
      end
      if (pend) begin
        if (age >= 2 && rr[d][own]) pend = 0;
        else if (age < 2) age++;
      end else if (w != 2'b00) begin
        own   = w[1] ? 1 : 0;
        pend  = 1;
        age   = 1;
        ea    = a[d][own];
        ef    = f[d][own];
        eres  = alu_ref(a[d][own], b[d][own], f[d][own]);
        lastg = own;
        acc[own] = 1'b1;
      end
    end
    v[d] = '0;
    rr[d] = 2'b11;
    repeat (4) @(negedge CLK);
    rr[d] = '0;
  endtask

  initial begin
    v = '0; rr = '0; a = '0; b = '0; f = '0;
    RST_N = 1'b0;
    #12;
    chk("reset_rvalid_rr", {rv[0][0], rv[0][1]}, 0);
    chk("reset_rvalid_fp", {rv[1][0], rv[1][1]}, 0);
    chk("reset_alu_a", alua[0], 0);
    chk("reset_alu_fun", aluf[0], 0);
    chk("reset_result", res[0][0], 0);
    @(negedge CLK);
    RST_N = 1'b1;

    // add 5+7
    do_txn(0, 0, 32'd5, 32'd7, 4'b0000, 0, 32'd12, 0, 0);

    // both valid from reset: REQ0 first, then REQ1
    do_reset();
    a[0][1] = 32'd1; b[0][1] = 32'hFFFF_FFFF; f[0][1] = 4'b0011; v[0][1] = 1'b1;
    do_txn(0, 0, 32'd10, 32'd3, 4'b1000, 0, 32'd7, 0, 0);
    do_txn(0, 1, 32'd1, 32'hFFFF_FFFF, 4'b0011, 0, 32'd1, 0, 0);

    // sra under 5 cycles of backpressure, REQ0 knocking meanwhile
    do_txn(0, 1, 32'h8000_0000, 32'd4, 4'b1101, 5, 32'hF800_0000, 0, 1);

    // invalid code and lui pass-through
    do_txn(0, 0, 32'h1234_5678, 32'd9, 4'b1111, 0, 32'd0, 0, 0);
    do_txn(0, 0, 32'hABCD_0000, 32'd0, 4'b1001, 0, 32'hABCD_0000, 0, 0);

    // fixed priority: REQ0 held valid, REQ1 never granted
    a[1][1] = 32'd9; b[1][1] = 32'd9; f[1][1] = 4'd0; v[1][1] = 1'b1;
    repeat (3) do_txn(1, 0, 32'd100, 32'd23, 4'b0000, 1, 32'd123, 1, 0);
    v[1] = '0;

    // reset during EXEC drops the job
    a[0][0] = 32'd3; b[0][0] = 32'd4; f[0][0] = 4'd0; v[0][0] = 1'b1;
    @(negedge CLK);
    v[0][0] = 1'b0;
    #1;
    chk("rst_pre_alu_a", alua[0], 32'd3);
    #2;
    RST_N = 1'b0;
    #1;
    chk("rst_rvalid", {rv[0][0], rv[0][1]}, 0);
    chk("rst_alu_a", alua[0], 0);
    chk("rst_alu_b", alub[0], 0);
    chk("rst_alu_fun", aluf[0], 0);
    chk("rst_result", res[0][0], 0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      #1;
      chk("rst_no_rvalid", rv[0][0], 0);
    end
    do_txn(0, 0, 32'd20, 32'd22, 4'b0000, 0, 32'd42, 0, 0);

    do_reset();
    rand_run(0, 400);
    do_reset();
    rand_run(1, 400);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
